// File: rtl/score_pkg.sv
// Shared glyph geometry and the digit-to-segment lookup for the score renderer.
package score_pkg;

    localparam int unsigned GLYPH_W = 12;
    localparam int unsigned GLYPH_H = 28;
    localparam int unsigned SEG_CNT = 7;

    // Segment rectangles, index 0..6 = a..g, inclusive bounds in glyph-local pixels.
    localparam int unsigned SEG_ROW_LO [SEG_CNT] = '{0, 0, 12, 24, 12, 0, 12};
    localparam int unsigned SEG_ROW_HI [SEG_CNT] = '{3, 15, 27, 27, 27, 15, 15};
    localparam int unsigned SEG_COL_LO [SEG_CNT] = '{0, 8, 8, 0, 0, 0, 0};
    localparam int unsigned SEG_COL_HI [SEG_CNT] = '{11, 11, 11, 11, 3, 3, 11};

    // Lit segments per decimal digit, bit order gfedcba.
    localparam logic [6:0] DIGIT_SEGS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] digit_segs(input logic [3:0] d);
        if (d < 4'd10) begin
            return DIGIT_SEGS[d];
        end
        return 7'd0;
    endfunction

endpackage

// File: rtl/score_glyph.sv
// Seven-segment glyph lookup: is pixel (row, col) of this digit's cell lit.
module score_glyph
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [9:0] row,
    input  logic [9:0] col,
    output logic       lit
);

    logic [6:0] segs_c;

    // Unsigned offset trick: a coordinate below the low bound wraps large and fails the test.
    always_comb begin
        segs_c = digit_segs(digit);
        lit    = 1'b0;
        for (int unsigned s = 0; s < SEG_CNT; s++) begin
            if (segs_c[s]
                && ((row - 10'(SEG_ROW_LO[s])) <= 10'(SEG_ROW_HI[s] - SEG_ROW_LO[s]))
                && ((col - 10'(SEG_COL_LO[s])) <= 10'(SEG_COL_HI[s] - SEG_COL_LO[s]))) begin
                lit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_display.sv
// N-digit BCD score with high-score tracking, per-frame snapshot, flashing and
// leading-zero blanking, rendered as a registered 3-bit banner pixel.
module score_display
    import score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 3,
    parameter int unsigned H_START         = 590,
    parameter int unsigned V_START         = 2,
    parameter int unsigned DIGIT_GAP       = 4,
    parameter bit          LEAD_ZERO_BLANK = 1'b1,
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter logic [2:0]  DIGIT_COLOR     = 3'b100,
    parameter logic [2:0]  BANNER_COLOR    = 3'b000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [9:0]              i_hpos,
    input  logic [9:0]              i_vpos,
    input  logic                    i_frame_start,
    input  logic                    i_inc,
    input  logic                    i_clear,
    output logic [4*NUM_DIGITS-1:0] o_score_bcd,
    output logic [4*NUM_DIGITS-1:0] o_high_bcd,
    output logic                    o_new_high,
    output logic [2:0]              o_score_rgb
);

    localparam int unsigned SW           = 4 * NUM_DIGITS;
    localparam int unsigned CELL_PITCH   = GLYPH_W + DIGIT_GAP;
    localparam int unsigned FLASH_PERIOD = 2 * FLASH_FRAMES;
    localparam int unsigned FW           = (FLASH_PERIOD > 2) ? $clog2(FLASH_PERIOD) : 1;

    logic [SW-1:0]         score_inc_c;
    logic                  all_nines_c;
    logic                  inc_carry_c;
    logic [SW-1:0]         snap;
    logic [FW-1:0]         flash_cnt;
    logic                  visible_c;
    logic [9:0]            cell_row_c;
    logic [NUM_DIGITS-1:0] in_cell_c;
    logic [NUM_DIGITS-1:0] lit_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  lead_zero_c;
    logic [2:0]            rgb_c;

    // Ripple-carry BCD increment plus saturation detect.
    always_comb begin
        score_inc_c = o_score_bcd;
        all_nines_c = 1'b1;
        inc_carry_c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (o_score_bcd[4*i +: 4] != 4'd9) begin
                all_nines_c = 1'b0;
            end
            if (inc_carry_c) begin
                if (o_score_bcd[4*i +: 4] == 4'd9) begin
                    score_inc_c[4*i +: 4] = 4'd0;
                end else begin
                    score_inc_c[4*i +: 4] = o_score_bcd[4*i +: 4] + 4'd1;
                    inc_carry_c           = 1'b0;
                end
            end
        end
    end

    // Valid BCD orders the same as its packed binary value, so a plain compare is MSD-first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_score_bcd <= '0;
            o_high_bcd  <= '0;
            o_new_high  <= 1'b0;
        end else begin
            if (i_clear) begin
                o_score_bcd <= '0;
            end else if (i_inc && !all_nines_c) begin
                o_score_bcd <= score_inc_c;
            end
            if (o_score_bcd > o_high_bcd) begin
                o_high_bcd <= o_score_bcd;
            end
            if (i_clear) begin
                o_new_high <= 1'b0;
            end else if (o_score_bcd > o_high_bcd) begin
                o_new_high <= 1'b1;
            end
        end
    end

    // Frame snapshot and flash phase counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap      <= '0;
            flash_cnt <= '0;
        end else begin
            if (i_frame_start) begin
                snap <= o_score_bcd;
            end
            if (!o_new_high) begin
                flash_cnt <= '0;
            end else if (i_frame_start) begin
                flash_cnt <= (flash_cnt == FW'(FLASH_PERIOD - 1)) ? '0 : flash_cnt + FW'(1);
            end
        end
    end

    assign visible_c  = !o_new_high || (flash_cnt < FW'(FLASH_FRAMES));
    assign cell_row_c = i_vpos - 10'(V_START);

    // Screen cell k shows digit NUM_DIGITS-1-k (MSD leftmost).
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_cell
        localparam int unsigned CELL_X = H_START + k * CELL_PITCH;
        logic [9:0] col_c;

        assign col_c        = i_hpos - 10'(CELL_X);
        assign in_cell_c[k] = (col_c < 10'(GLYPH_W)) && (cell_row_c < 10'(GLYPH_H));

        score_glyph u_glyph (
            .digit (snap[4*(NUM_DIGITS-1-k) +: 4]),
            .row   (cell_row_c),
            .col   (col_c),
            .lit   (lit_c[k])
        );
    end

    always_comb begin
        lead_zero_c = 1'b1;
        blank_c     = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            lead_zero_c = lead_zero_c && (snap[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank_c[k]  = LEAD_ZERO_BLANK && lead_zero_c && (k != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        rgb_c = 3'b000;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (in_cell_c[k]) begin
                rgb_c = (lit_c[k] && !blank_c[k] && visible_c) ? DIGIT_COLOR : BANNER_COLOR;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_score_rgb <= 3'b000;
        end else begin
            o_score_rgb <= rgb_c;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Randomised and directed bench for score_display against an arithmetic reference model.
module tb_score_display;

    localparam int N    = 3;
    localparam int FF   = 2;
    localparam int HS   = 590;
    localparam int VS   = 2;
    localparam int GAP  = 4;
    localparam int MAXS = 999;
    localparam logic [2:0] DC = 3'b100;
    localparam logic [2:0] BC = 3'b000;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [9:0]    i_hpos = '0;
    logic [9:0]    i_vpos = '0;
    logic          i_frame_start = 1'b0;
    logic          i_inc = 1'b0;
    logic          i_clear = 1'b0;
    logic [4*N-1:0] o_score_bcd;
    logic [4*N-1:0] o_high_bcd;
    logic          o_new_high;
    logic [2:0]    o_score_rgb;

    int n_vec = 0;
    int n_err = 0;

    score_display #(
        .NUM_DIGITS(N), .H_START(HS), .V_START(VS), .DIGIT_GAP(GAP),
        .LEAD_ZERO_BLANK(1'b1), .FLASH_FRAMES(FF), .DIGIT_COLOR(DC), .BANNER_COLOR(BC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_frame_start(i_frame_start), .i_inc(i_inc), .i_clear(i_clear),
        .o_score_bcd(o_score_bcd), .o_high_bcd(o_high_bcd),
        .o_new_high(o_new_high), .o_score_rgb(o_score_rgb)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    int         m_score = 0;
    int         m_high = 0;
    bit         m_new_high = 1'b0;
    int         m_snap = 0;
    int         m_pulses = 0;
    logic [2:0] m_rgb = 3'b000;

    function automatic int pow10(int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic string seg_names(int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit has_seg(int d, byte ch);
        string s = seg_names(d);
        for (int i = 0; i < s.len(); i++) if (s[i] == ch) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit seg_on(int d, int r, int c);
        return (has_seg(d, "a") && r < 4)
            || (has_seg(d, "b") && r < 16 && c >= 8)
            || (has_seg(d, "c") && r >= 12 && c >= 8)
            || (has_seg(d, "d") && r >= 24)
            || (has_seg(d, "e") && r >= 12 && c < 4)
            || (has_seg(d, "f") && r < 16 && c < 4)
            || (has_seg(d, "g") && r >= 12 && r < 16);
    endfunction

    function automatic logic [2:0] pixel(int h, int v, int snap, bit nh, int pulses);
        for (int k = 0; k < N; k++) begin
            int x0 = HS + k * (12 + GAP);
            if (h >= x0 && h < x0 + 12 && v >= VS && v < VS + 28) begin
                int  p     = pow10(N - 1 - k);
                int  d     = (snap / p) % 10;
                bit  blank = (k != N - 1) && (snap < p);
                bit  vis   = !nh || ((pulses % (2 * FF)) < FF);
                return (!blank && vis && seg_on(d, v - VS, h - x0)) ? DC : BC;
            end
        end
        return 3'b000;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_score    <= 0;
            m_high     <= 0;
            m_new_high <= 1'b0;
            m_snap     <= 0;
            m_pulses   <= 0;
            m_rgb      <= 3'b000;
        end else begin
            m_score    <= i_clear ? 0 : ((i_inc && m_score < MAXS) ? m_score + 1 : m_score);
            if (m_score > m_high) m_high <= m_score;
            m_new_high <= i_clear ? 1'b0 : ((m_score > m_high) ? 1'b1 : m_new_high);
            if (i_frame_start) m_snap <= m_score;
            m_pulses   <= !m_new_high ? 0 : (i_frame_start ? m_pulses + 1 : m_pulses);
            m_rgb      <= pixel(int'(i_hpos), int'(i_vpos), m_snap, m_new_high, m_pulses);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge i_clk) begin
        chk("score_bcd", 32'(o_score_bcd), 32'(to_bcd(m_score)));
        chk("high_bcd",  32'(o_high_bcd),  32'(to_bcd(m_high)));
        chk("new_high",  32'(o_new_high),  32'(m_new_high));
        chk("rgb",       32'(o_score_rgb), 32'(m_rgb));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit inc, input bit clr, input bit fs);
        i_inc         = inc;
        i_clear       = clr;
        i_frame_start = fs;
        i_hpos        = 10'($urandom_range(580, 645));
        i_vpos        = 10'($urandom_range(0, 35));
        @(negedge i_clk);
        i_inc = 1'b0; i_clear = 1'b0; i_frame_start = 1'b0;
    endtask

    task automatic pix(input int h, input int v, input logic [2:0] want, input string name);
        i_hpos = 10'(h);
        i_vpos = 10'(v);
        @(negedge i_clk);
        chk(name, 32'(o_score_rgb), 32'(want));
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] flash_exp [5];
        flash_exp[0] = DC; flash_exp[1] = DC; flash_exp[2] = BC;
        flash_exp[3] = BC; flash_exp[4] = DC;

        @(negedge i_clk);
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        chk("rst_rgb",   32'(o_score_rgb), 32'd0);
        chk("rst_score", 32'(o_score_bcd), 32'd0);
        chk("rst_high",  32'(o_high_bcd),  32'd0);
        chk("rst_newhi", 32'(o_new_high),  32'd0);
        i_rst_n = 1'b1;

        // Render a 7 in the LSD cell with leading zeros blanked.
        repeat (7) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end
        cyc(1'b0, 1'b0, 1'b1);
        chk("score7", 32'(o_score_bcd), 32'h007);
        for (int h = 622; h <= 633; h++) pix(h, 3, DC, "lsd_seg_a");
        pix(595, 3, BC, "hundreds_blank");
        pix(611, 3, BC, "tens_blank");
        pix(627, 16, BC, "lsd_seg_g_off");

        // Clear beats a same-cycle increment.
        repeat (35) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("score42", 32'(o_score_bcd), 32'h042);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("clr_score", 32'(o_score_bcd), 32'h000);
        chk("clr_high",  32'(o_high_bcd),  32'h042);
        chk("clr_newhi", 32'(o_new_high),  32'd0);

        // Carry chain up to saturation.
        repeat (999) cyc(1'b1, 1'b0, 1'b0);
        chk("sat999", 32'(o_score_bcd), 32'h999);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sat_hold", 32'(o_score_bcd), 32'h999);

        // Snapshot takes the pre-increment score.
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        pix(623, 22, BC, "snap_5_no_e");
        cyc(1'b0, 1'b0, 1'b1);
        pix(623, 22, DC, "snap_6_e");

        // New-high flag and flash cadence.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("flash_high",  32'(o_high_bcd), 32'h001);
        chk("flash_newhi", 32'(o_new_high), 32'd1);
        pix(631, 3, flash_exp[0], "flash_frame");
        for (int f = 1; f < 5; f++) begin
            cyc(1'b0, 1'b0, 1'b1);
            pix(631, 3, flash_exp[f], "flash_frame");
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 24) == 0);
        end

        // Reset asserted mid-cycle kills the pixel at once.
        i_hpos = 10'd631; i_vpos = 10'd3;
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 chk("midrst_rgb", 32'(o_score_rgb), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        pix(631, 3, DC, "post_rst_zero");
        repeat (20) cyc(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Parametrised successor to the fixed 3-digit score renderer. Holds the score itself as an N-digit BCD counter and tracks a high score.
- Latches a tear-free display snapshot once per frame and blanks leading zeros as an option. Flashes the digits while a new high score is active.
- Sits in the top-banner path and feeds o_score_rgb to the pixel mux, where black means no draw.

Parameters:
- NUM_DIGITS, 3: number of BCD digits, 1..6.
- H_START, 590: hpos of the left edge of the most significant digit cell.
- V_START, 2: vpos of the top of the digit cells.
- DIGIT_GAP, 4: horizontal pixels between adjacent cells.
- LEAD_ZERO_BLANK, 1: 1 means leading zero digits are drawn as background; the least significant digit is always drawn.
- FLASH_FRAMES, 8: frames per flash half-period, must be at least 1.
- DIGIT_COLOR, 3'b100: lit-segment colour.
- BANNER_COLOR, 3'b000: unlit colour inside the cells.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hpos  in  10  current horizontal pixel.
- i_vpos  in  10  current vertical pixel.
- i_frame_start  in  1  one-cycle pulse at the start of each frame.
- i_inc  in  1  one-cycle pulse: score +1.
- i_clear  in  1  one-cycle pulse: score to 0, clear new-high flag.
- o_score_bcd  out  4*NUM_DIGITS  live score, digit 0 (LSD) in bits [3:0].
- o_high_bcd  out  4*NUM_DIGITS  high score, same packing.
- o_new_high  out  1  high score was raised since the last clear/reset.
- o_score_rgb  out  3  registered pixel colour.

Behaviour:
- Reset (async assert, sync release): score, high, snapshot, flash counter and o_score_rgb are all 0; o_new_high is 0.
- Score counter:
  - On i_inc, BCD +1 with ripple carry; a digit at 9 wraps to 0 and carries.
  - If every digit is 9, i_inc is ignored (saturate); the counter never wraps to 0.
  - i_clear has priority over i_inc in the same cycle: score becomes 0.
  - Updates are visible on o_score_bcd the cycle after the pulse.
- High score:
  - Each cycle, if score > high (digit-wise BCD compare, MSD first), then high <= score and o_new_high <= 1.
  - High therefore lags score by one cycle.
  - i_clear does not change high; it sets o_new_high <= 0, and this overrides a same-cycle set.
- Snapshot: on i_frame_start, snap <= live score; rendering uses only snap. An i_inc in the same cycle is seen at the next frame.
- Flash:
  - While o_new_high = 1, count i_frame_start pulses modulo 2*FLASH_FRAMES.
  - Phase visible when count < FLASH_FRAMES, otherwise digits render as BANNER_COLOR.
  - The counter is held at 0 (visible) while o_new_high = 0.
- Geometry:
  - Cell k (k=0 is the MSD on screen) spans hpos [H_START + k*(GLYPH_W+DIGIT_GAP), +GLYPH_W) and vpos [V_START, V_START+GLYPH_H).
  - Local col = hpos − cell start and row = vpos − V_START, both unsigned, computed at 10 bits.
- Segments (on the 12x28 glyph):
  - a: rows 0-3, cols 0-11.
  - b: rows 0-15, cols 8-11.
  - c: rows 12-27, cols 8-11.
  - d: rows 24-27, cols 0-11.
  - e: rows 12-27, cols 0-3.
  - f: rows 0-15, cols 0-3.
  - g: rows 12-15, cols 0-11.
- Segment map:
  - 0: abcdef.
  - 1: bc.
  - 2: abdeg.
  - 3: abcdg.
  - 4: bcfg.
  - 5: acdfg.
  - 6: acdefg.
  - 7: abc.
  - 8: abcdefg.
  - 9: abcdfg.
  - BCD codes 10-15 are unreachable and render blank.
- Leading-zero blanking: a digit is blank when LEAD_ZERO_BLANK=1, it is 0, every more significant digit is 0, and it is not the LSD.
- Pixel output:
  - o_score_rgb is registered, 1-cycle latency from i_hpos/i_vpos.
  - Outside all cells: 3'b000.
  - Inside a cell: DIGIT_COLOR if the segment is lit, the digit is not blanked and the flash phase is visible; otherwise BANNER_COLOR.
  - Gap columns between cells: 3'b000.
- Reset mid-frame: o_score_rgb drops to 0 immediately. Drawing resumes at the next i_frame_start with snapshot 0.

Decomposition:
- Package score_pkg holds GLYPH_W=12, GLYPH_H=28, the segment rectangle constants, and the 10-entry digit-to-segment mask (7 bits, order gfedcba).
- Sub-module score_glyph is purely combinational: inputs 4-bit digit and local row/col, output lit.
- The top level owns the BCD counter, compare, snapshot, flash counter, cell decode and output register.

Test Plan:
- Reset: hold i_rst_n=0 with random hpos/vpos -> o_score_rgb=0, o_score_bcd=0, o_high_bcd=0, o_new_high=0.
- Render: 7 i_inc pulses, then i_frame_start, then scan vpos=3 (V_START+1) across the LSD cell at hpos 622..633 (col 0-11, row 1) -> DIGIT_COLOR 1 cycle after each hpos (segment a lit for 7). Hundreds and tens cells read BANNER_COLOR (leading zeros blanked).
- Carry and saturation (NUM_DIGITS=3): 999 i_inc pulses -> o_score_bcd=12'h999. One more i_inc -> still 12'h999.
- Clear priority: score 42, assert i_clear and i_inc together -> score 0, o_high_bcd=12'h042, o_new_high=0.
- High/flash (FLASH_FRAMES=2): i_inc from 0 -> o_high_bcd=1 and o_new_high=1 two cycles after the pulse. Frames 0-1 show digits, frames 2-3 are blank, frame 4 shows digits.
- Snapshot: i_inc and i_frame_start in the same cycle at score 5 -> the frame renders 5, the next frame renders 6.
